// File: rtl/stall_mem_if.sv
// Request/response bus between the datapath's data-memory port and stall_mem.
interface stall_mem_if;
  // Handshake: the requester raises exactly one of Rd/Wr with an even Addr
  // (and DataIn for stores). The request is taken in any cycle where the
  // responder is not BUSY. While Stall is high, the requester holds and waits.
  // Done pulses for one cycle when the request completes. DataOut is
  // meaningful only in that cycle. err flags a malformed request, which is
  // then dropped.
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        err;

  modport master (
    output Addr, DataIn, Rd, Wr,
    input  DataOut, Done, Stall, err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr,
    output DataOut, Done, Stall, err
  );
endinterface

// File: rtl/stall_mem.sv
// Fixed-latency, stalling 16-bit data memory: each accepted load/store waits
// LATENCY cycles, then completes with a one-cycle Done pulse.
module stall_mem #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 4
) (
  input  logic       clk,
  input  logic       rst,
  stall_mem_if.slave bus,
  output logic [1:0] state_o
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [15:0]          din_q, din_d;
  logic                 wr_q, wr_d;
  logic [15:0]          dout_q, dout_d;
  logic [15:0]          mem_q [DEPTH];

  logic accepting;
  logic req_legal;
  logic req_illegal;
  logic accept;
  logic finish;

  always_comb begin
    accepting   = (state_q != S_BUSY);
    req_legal   = (bus.Rd ^ bus.Wr) && !bus.Addr[0];
    req_illegal = (bus.Rd && bus.Wr) || ((bus.Rd || bus.Wr) && bus.Addr[0]);
    accept      = accepting && req_legal && !rst;
    finish      = (state_q == S_BUSY) && (cnt_q == 4'd1);
  end

  // Upper address bits do not select a word, so addresses alias.
  if (ADDR_BITS < 15) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.Addr[15:ADDR_BITS+1];
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept ? S_BUSY : S_IDLE;
      S_BUSY:  state_d = (cnt_q == 4'd1) ? S_DONE : S_BUSY;
      S_DONE:  state_d = accept ? S_BUSY : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. Stall stays low in DONE even when a back-to-back request is taken.
  always_comb begin
    bus.Stall   = !rst && ((state_q == S_BUSY) || ((state_q == S_IDLE) && accept));
    bus.Done    = !rst && (state_q == S_DONE);
    bus.err     = !rst && accepting && req_illegal;
    bus.DataOut = dout_q;
    state_o     = state_q;
  end

  // Request latch, latency counter and load result
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    din_d  = din_q;
    wr_d   = wr_q;
    dout_d = '0;
    if (accept) begin
      cnt_d = CNT_LOAD;
      idx_d = bus.Addr[ADDR_BITS:1];
      din_d = bus.DataIn;
      wr_d  = bus.Wr;
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (finish && !wr_q) dout_d = mem_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      din_q  <= '0;
      wr_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      din_q  <= din_d;
      wr_q   <= wr_d;
      dout_q <= dout_d;
    end
  end

  // A store commits on the edge entering DONE. A load of the same word
  // accepted in that DONE cycle therefore sees the new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (finish && wr_q) begin
      mem_q[idx_q] <= din_q;
    end
  end

endmodule

// File: doc/stall_mem.md
# stall_mem

Multi-cycle, stalling 16-bit data-memory responder. It sits on the far side of the processor's data-memory port and answers the load/store requests the datapath issues. Each accepted request is held for a fixed, parameterized latency. The block raises `Stall` while the request is in flight and pulses `Done` for one cycle when it completes. This lets the processor be tested against a non-ideal memory without changing the datapath.

## Interface
- `ADDR_BITS`, default 8: the array holds 2^ADDR_BITS 16-bit words.
- `LATENCY`, default 4: cycles from request acceptance to `Done`. Legal range is 2..15.
- `clk` input, 1 bit: the single clock. All state changes on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `Addr` input, 16 bits: byte address. Must be even. Word index is `Addr[ADDR_BITS:1]`.
- `DataIn` input, 16 bits: store data.
- `Rd` input, 1 bit: load request.
- `Wr` input, 1 bit: store request.
- `DataOut` output, 16 bits: load result. Valid only in the `Done` cycle.
- `Done` output, 1 bit: one-cycle completion pulse.
- `Stall` output, 1 bit: requester must hold and wait.
- `err` output, 1 bit: illegal request flag. It is ORed into the processor's `err`.

## Operation
- The FSM has three states.
  - IDLE: no request in flight.
  - BUSY: a request is waiting out its latency.
  - DONE: the cycle the request completes and `Done` is high.
- Accepting cycle: any cycle in IDLE or DONE.
  - In an accepting cycle, a request is Rd XOR Wr with `Addr[0]`=0.
  - On acceptance, the block latches `Addr`, `DataIn` and the op, loads the 4-bit down-counter with `LATENCY-1`, and goes to BUSY.
- BUSY: the counter decrements each cycle. When the count is 1, the next state is DONE.
  - At the edge entering DONE, a store writes `mem[idx] <= DataIn_latched`.
  - At that same edge, a load registers `DataOut <= mem[idx]`.
- DONE: `Done`=1 for exactly one cycle.
  - With no new request, the next state is IDLE.
  - With a new legal request, the block accepts it (back-to-back) and goes to BUSY.
- Illegal requests, checked only in accepting cycles:
  - Cases: Rd&Wr both high, or (Rd|Wr) with `Addr[0]`=1.
  - Response: `err`=1 combinationally in that cycle, `Stall`=0, and the request is ignored with no state change and no write.
- `Rd`/`Wr`/`Addr`/`DataIn` are ignored during BUSY. The request is already latched, and `err` is never raised in BUSY.
- Address bits above `ADDR_BITS` are ignored, so addresses alias modulo 2^(ADDR_BITS+1) bytes.
- `DataOut`:
  - Load: the word read from the array, held only in the DONE cycle.
  - Store: 0x0000.
  - Outside DONE: 0x0000.
- A read in DONE and an accept of a new store to the same word in the same cycle: the read result is the old data. The new store commits LATENCY cycles later.

## Timing
- Request accepted in cycle T:
  - `Stall`=1 in cycles T..T+LATENCY-1. It is combinational in cycle T and registered from state thereafter.
  - `Done`=1 and `Stall`=0 in cycle T+LATENCY.
- Back-to-back: with a request accepted in DONE cycle T+L, the next `Done` is at T+2L. Throughput is one request per LATENCY cycles.
- A store is visible to any load accepted at or after its `Done` cycle.
- Reset: a synchronous clear on the edge with `rst`=1.
  - State goes to IDLE, the counter to 0, and all array words to 0x0000.
  - `DataOut`=0x0000, `Done`=0, `Stall`=0, `err`=0.
- Reset mid-operation: any in-flight request is aborted and a pending store is dropped. No `Done` is produced for it.
- `err`, `Stall` and `Done` are never 1 while `rst` is high.

## Test plan
- Store then load, LATENCY=4:
  - Stimulus: Wr, Addr=0x0010, DataIn=0xBEEF at T.
  - Required: `Stall` high T..T+3, `Done` at T+4.
  - Then Rd at T+5 to Addr=0x0010 gives `Done` at T+9 with `DataOut`=0xBEEF.
- Back-to-back:
  - Stimulus: Rd to 0x0002 held high through the DONE cycle, with word 1 preloaded to 0x1234.
  - Required: `Done` pulses at T+4 and T+8, each with `DataOut`=0x1234. `Stall` is low only in the DONE cycles.
- Illegal requests:
  - Rd with Addr=0x0003 in IDLE gives `err`=1 that cycle, `Stall`=0, and the state stays IDLE.
  - Rd&Wr together gives the same result.
  - Rd&Wr during BUSY gives `err`=0.
- Reset mid-store:
  - Stimulus: Wr 0xAAAA to 0x0020, then `rst` pulse at T+2.
  - Required: no `Done`. A later Rd of 0x0020 returns 0x0000.
- Aliasing, ADDR_BITS=8:
  - Stimulus: Wr 0x5A5A to 0x0204, then Rd 0x0004.
  - Required: `DataOut`=0x5A5A.
- LATENCY=2 corner case:
  - Required: `Stall` high exactly T..T+1 and `Done` at T+2.
